// File: rtl/hub75_bcm_scanner_if.sv
// Frame-buffer read port of the HUB75 BCM scanner: strobe/address out, pixel pair back
// exactly one cycle after the strobe.
interface hub75_bcm_scanner_if #(
  parameter int unsigned ROW_W        = 4,
  parameter int unsigned COL_W        = 6,
  parameter int unsigned COLOUR_DEPTH = 8
);
  logic                      pix_rd_en_out;
  logic [ROW_W-1:0]          pix_row_out;
  logic [COL_W-1:0]          pix_col_out;
  logic [3*COLOUR_DEPTH-1:0] pix_top_in;
  logic [3*COLOUR_DEPTH-1:0] pix_bot_in;

  modport master (
    output pix_rd_en_out,
    output pix_row_out,
    output pix_col_out,
    input  pix_top_in,
    input  pix_bot_in
  );

  modport slave (
    input  pix_rd_en_out,
    input  pix_row_out,
    input  pix_col_out,
    output pix_top_in,
    output pix_bot_in
  );
endinterface

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scanner with binary-coded modulation: per row and bitplane it fetches, shifts, blanks,
// latches and lights for LSB_ON_CYCLES << plane. Optional macro HUB75_BRIGHTNESS_EN adds dimming.
module hub75_bcm_scanner #(
  parameter int unsigned NUM_ROWS      = 32,
  parameter int unsigned NUM_COLS      = 64,
  parameter int unsigned COLOUR_DEPTH  = 8,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned LSB_ON_CYCLES = 32,
  parameter int unsigned BLANK_CYCLES  = 8,
  parameter int unsigned LATCH_CYCLES  = 2,
  localparam int unsigned ROW_W        = $clog2(NUM_ROWS / 2),
  localparam int unsigned COL_W        = $clog2(NUM_COLS)
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               enable_in,
  hub75_bcm_scanner_if.master fb,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]         brightness_in,
`endif
  output logic               frame_start_out,
  output logic [2:0]         rgb_top_out,
  output logic [2:0]         rgb_bot_out,
  output logic               bit_clk_out,
  output logic               latch_enable_out,
  output logic               output_enable_n_out,
  output logic [ROW_W-1:0]   addr_out
);

  localparam int unsigned SCAN_ROWS = NUM_ROWS / 2;
  localparam int unsigned PLANE_W   = (COLOUR_DEPTH > 1) ? $clog2(COLOUR_DEPTH) : 1;
  localparam int unsigned MAX_ON    = LSB_ON_CYCLES << (COLOUR_DEPTH - 1);
  localparam int unsigned MAX_A     = (MAX_ON > CLK_DIV) ? MAX_ON : CLK_DIV;
  localparam int unsigned MAX_B     = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
  localparam int unsigned MAX_LEN   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W     = $clog2(MAX_LEN + 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StShiftLo = 3'd3;
  localparam logic [2:0] StShiftHi = 3'd4;
  localparam logic [2:0] StBlank   = 3'd5;
  localparam logic [2:0] StLatch   = 3'd6;
  localparam logic [2:0] StDisplay = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d, addr_q, addr_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         top_q, top_d, bot_q, bot_d;
  logic               frame_start_q, frame_start_d;
  logic [CNT_W-1:0]   len, on_len, lit_len;
  logic               last;

  assign on_len = CNT_W'(LSB_ON_CYCLES) << plane_q;

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]       bright_q, bright_d;
  logic [CNT_W+7:0] lit_prod;

  // Brightness is frozen for the whole plane so the lit window cannot jitter mid-plane.
  assign bright_d = (state_q == StLatch && last) ? brightness_in : bright_q;
  assign lit_prod = {8'd0, on_len} * {{CNT_W{1'b0}}, bright_q};
  assign lit_len  = CNT_W'(lit_prod >> 8);

  always_ff @(posedge clk_in) begin
    if (reset_in) bright_q <= 8'd0;
    else          bright_q <= bright_d;
  end
`else
  assign lit_len = on_len;
`endif

  always_comb begin
    case (state_q)
      StShiftLo, StShiftHi: len = CNT_W'(CLK_DIV);
      StBlank:              len = CNT_W'(BLANK_CYCLES);
      StLatch:              len = CNT_W'(LATCH_CYCLES);
      StDisplay:            len = on_len;
      default:              len = CNT_W'(1);
    endcase
  end

  assign last = (cnt_q == len - CNT_W'(1));

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    plane_d       = plane_q;
    col_d         = col_q;
    addr_d        = addr_q;
    top_d         = top_q;
    bot_d         = bot_q;
    frame_start_d = 1'b0;
    cnt_d         = last ? '0 : cnt_q + 1'b1;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable_in) begin
          state_d       = StFetch;
          frame_start_d = 1'b1;
        end
      end
      StFetch: state_d = StCapture;
      StCapture: begin
        for (int ch = 0; ch < 3; ch++) begin
          top_d[ch] = fb.pix_top_in[ch * COLOUR_DEPTH + int'(plane_q)];
          bot_d[ch] = fb.pix_bot_in[ch * COLOUR_DEPTH + int'(plane_q)];
        end
        state_d = StShiftLo;
      end
      StShiftLo: if (last) state_d = StShiftHi;
      StShiftHi: begin
        if (last) begin
          if (col_q == COL_W'(NUM_COLS - 1)) begin
            col_d   = '0;
            addr_d  = row_q;
            state_d = StBlank;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StBlank: if (last) state_d = StLatch;
      StLatch: if (last) state_d = StDisplay;
      StDisplay: begin
        if (last) begin
          if (!enable_in) begin
            state_d = StIdle;
            row_d   = '0;
            plane_d = '0;
            addr_d  = '0;
          end else begin
            state_d = StFetch;
            if (plane_q == PLANE_W'(COLOUR_DEPTH - 1)) begin
              plane_d = '0;
              if (row_q == ROW_W'(SCAN_ROWS - 1)) begin
                row_d         = '0;
                frame_start_d = 1'b1;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              plane_d = plane_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q       <= StIdle;
      row_q         <= '0;
      plane_q       <= '0;
      col_q         <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      top_q         <= '0;
      bot_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      col_q         <= col_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      top_q         <= top_d;
      bot_q         <= bot_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb.pix_rd_en_out    = (state_q == StFetch);
  assign fb.pix_row_out      = row_q;
  assign fb.pix_col_out      = col_q;
  assign frame_start_out     = frame_start_q;
  assign bit_clk_out         = (state_q == StShiftHi);
  assign latch_enable_out    = (state_q == StLatch);
  assign output_enable_n_out = !((state_q == StDisplay) && (cnt_q < lit_len));
  assign addr_out            = addr_q;
  assign rgb_top_out = (state_q == StShiftLo || state_q == StShiftHi) ? top_q : 3'b000;
  assign rgb_bot_out = (state_q == StShiftLo || state_q == StShiftHi) ? bot_q : 3'b000;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner on a 4x4 panel, 2 bitplanes; covers HUB75_BRIGHTNESS_EN
// when that macro is defined for the build.
module tb_hub75_bcm_scanner;

  logic       clk_in;
  logic       reset_in;
  logic       enable_in;
  logic       frame_start_out;
  logic [2:0] rgb_top_out;
  logic [2:0] rgb_bot_out;
  logic       bit_clk_out;
  logic       latch_enable_out;
  logic       output_enable_n_out;
  logic [0:0] addr_out;
  logic [5:0] top_pix;
  logic [5:0] bot_pix;
  int         checks;
  int         errors;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] bright;
`endif

  hub75_bcm_scanner_if #(.ROW_W(1), .COL_W(2), .COLOUR_DEPTH(2)) fb ();

  hub75_bcm_scanner #(
    .NUM_ROWS      (4),
    .NUM_COLS      (4),
    .COLOUR_DEPTH  (2),
    .CLK_DIV       (1),
    .LSB_ON_CYCLES (4),
    .BLANK_CYCLES  (2),
    .LATCH_CYCLES  (1)
  ) dut (
    .clk_in              (clk_in),
    .reset_in            (reset_in),
    .enable_in           (enable_in),
    .fb                  (fb.master),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness_in       (bright),
`endif
    .frame_start_out     (frame_start_out),
    .rgb_top_out         (rgb_top_out),
    .rgb_bot_out         (rgb_bot_out),
    .bit_clk_out         (bit_clk_out),
    .latch_enable_out    (latch_enable_out),
    .output_enable_n_out (output_enable_n_out),
    .addr_out            (addr_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Frame-buffer model: every pixel of the panel holds the same pair, one-cycle read latency.
  always @(posedge clk_in) begin
    if (fb.pix_rd_en_out) begin
      fb.pix_top_in <= top_pix;
      fb.pix_bot_in <= bot_pix;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int on_for(input int len);
`ifdef HUB75_BRIGHTNESS_EN
    return (len * int'(bright)) >> 8;
`else
    return len;
`endif
  endfunction

  // Walks one whole plane cycle by cycle; the next negedge must be the plane's first FETCH.
  task automatic run_plane(input string tag, input bit exp_fs, input int row, input int prev_addr,
                           input logic [2:0] exp_top, input logic [2:0] exp_bot,
                           input int len, input int on, input bit drop);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      if (c == 0) check($sformatf("%s.fs", tag), frame_start_out, exp_fs);
      check($sformatf("%s.rd%0d", tag, c), fb.pix_rd_en_out, 1);
      check($sformatf("%s.row%0d", tag, c), fb.pix_row_out, row);
      check($sformatf("%s.col%0d", tag, c), fb.pix_col_out, c);
      if (drop && c == 1) enable_in = 1'b0;
      @(negedge clk_in);
      check($sformatf("%s.rd_off%0d", tag, c), fb.pix_rd_en_out, 0);
      if (c == 0) check($sformatf("%s.fs_pulse", tag), frame_start_out, 0);
      @(negedge clk_in);
      check($sformatf("%s.bclk_lo%0d", tag, c), bit_clk_out, 0);
      @(negedge clk_in);
      check($sformatf("%s.bclk_hi%0d", tag, c), bit_clk_out, 1);
      check($sformatf("%s.top%0d", tag, c), rgb_top_out, exp_top);
      check($sformatf("%s.bot%0d", tag, c), rgb_bot_out, exp_bot);
      check($sformatf("%s.addr_hold%0d", tag, c), addr_out, prev_addr);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      check($sformatf("%s.blank_oe%0d", tag, i), output_enable_n_out, 1);
      check($sformatf("%s.blank_le%0d", tag, i), latch_enable_out, 0);
      check($sformatf("%s.blank_rgb%0d", tag, i), {rgb_top_out, rgb_bot_out}, 0);
      check($sformatf("%s.blank_addr%0d", tag, i), addr_out, row);
    end
    @(negedge clk_in);
    check($sformatf("%s.latch", tag), latch_enable_out, 1);
    check($sformatf("%s.latch_oe", tag), output_enable_n_out, 1);
    for (int i = 0; i < len; i++) begin
      @(negedge clk_in);
      check($sformatf("%s.oe%0d", tag, i), output_enable_n_out, (i >= on));
      check($sformatf("%s.disp_le%0d", tag, i), latch_enable_out, 0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_in  = 1'b1;
    enable_in = 1'b0;
    top_pix   = 6'b00_00_11;
    bot_pix   = 6'b00_00_00;
`ifdef HUB75_BRIGHTNESS_EN
    bright    = 8'd255;
`endif
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst.oe_n", output_enable_n_out, 1);
    check("rst.le", latch_enable_out, 0);
    check("rst.bclk", bit_clk_out, 0);
    check("rst.rgb", {rgb_top_out, rgb_bot_out}, 0);
    check("rst.addr", addr_out, 0);
    check("rst.fs", frame_start_out, 0);
    check("rst.rd", fb.pix_rd_en_out, 0);
    check("rst.rowcol", {fb.pix_row_out, fb.pix_col_out}, 0);
    reset_in = 1'b0;
    @(negedge clk_in);
    check("idle.rd", fb.pix_rd_en_out, 0);
    check("idle.oe_n", output_enable_n_out, 1);
    enable_in = 1'b1;

    // R=11 on top: both planes shift a red bit on top
    run_plane("r0p0", 1, 0, 0, 3'b001, 3'b000, 4, on_for(4), 0);
    run_plane("r0p1", 0, 0, 0, 3'b001, 3'b000, 8, on_for(8), 0);

    // Top R=10, bottom G=01: plane 0 picks bit 0, plane 1 picks bit 1
    top_pix = 6'b00_00_10;
    bot_pix = 6'b00_01_00;
    run_plane("r1p0", 0, 1, 0, 3'b000, 3'b010, 4, on_for(4), 0);
    run_plane("r1p1", 0, 1, 1, 3'b001, 3'b000, 8, on_for(8), 0);
    run_plane("wrap_r0p0", 1, 0, 1, 3'b000, 3'b010, 4, on_for(4), 0);

    // Drop enable while shifting plane 1: plane still completes in full
    run_plane("drop_r0p1", 0, 0, 0, 3'b001, 3'b000, 8, on_for(8), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check($sformatf("stop.rd%0d", i), fb.pix_rd_en_out, 0);
      check($sformatf("stop.oe_n%0d", i), output_enable_n_out, 1);
      check($sformatf("stop.fs%0d", i), frame_start_out, 0);
      check($sformatf("stop.addr%0d", i), addr_out, 0);
    end
    enable_in = 1'b1;
    run_plane("restart_r0p0", 1, 0, 0, 3'b000, 3'b010, 4, on_for(4), 0);

`ifdef HUB75_BRIGHTNESS_EN
    bright = 8'd128;
    run_plane("br128_r0p1", 0, 0, 0, 3'b001, 3'b000, 8, 4, 0);
    run_plane("br128_r1p0", 0, 1, 0, 3'b000, 3'b010, 4, 2, 0);
    bright = 8'd0;
    run_plane("br0_r1p1", 0, 1, 1, 3'b001, 3'b000, 8, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
